// File: rtl/sys_timer_pkg.sv
// Shared register map, TCON bit layout and FSM encodings for the system timer.
// No logic of its own; the address decode helper is pure combinational.
package sys_timer_pkg;

    localparam logic [31:0] OFF_TH   = 32'h0000_0000;
    localparam logic [31:0] OFF_TL   = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON = 32'h0000_0008;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IF = 2;
    localparam int TCON_OS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_TH   = 2'd0,
        REG_TL   = 2'd1,
        REG_TCON = 2'd2,
        REG_NONE = 2'd3
    } reg_sel_t;

    // Field order matches the TCON bit indices above.
    typedef struct packed {
        logic os;
        logic iflag;
        logic ie;
        logic en;
    } tcon_t;

    function automatic reg_sel_t decode_addr(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        if (off == OFF_TH)        return REG_TH;
        else if (off == OFF_TL)   return REG_TL;
        else if (off == OFF_TCON) return REG_TCON;
        else                      return REG_NONE;
    endfunction

endpackage

// File: rtl/sys_timer_tick_prescaler.sv
// Divides clk by PRESCALE while enabled; tick is high for the last count of each period.
// Latency: tick is combinational from the counter; clear restarts the period at 0.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/sys_timer.sv
// Memory-mapped 32-bit up-counting timer with reload, one-shot mode and level interrupt.
// Latency: register writes take effect on the write edge, reads are combinational; no backpressure.
module sys_timer
    import sys_timer_pkg::*;
#(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tick
);

    logic [1:0]  rst_sync;
    logic        rst_n;
    reg_sel_t    sel;
    logic        th_wr;
    logic        tl_wr;
    logic        tcon_wr;
    logic [31:0] th;
    logic [31:0] tl;
    tcon_t       tcon;
    state_t      state;
    logic        run;
    logic        tick_i;
    logic        ovf;
    logic        enter_run;

    // Assertion is immediate; release is aligned to clk so no flop sees a runt edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1] & reset;

    assign sel     = decode_addr(addr, BASE_ADDR);
    assign th_wr   = mem_write && (sel == REG_TH);
    assign tl_wr   = mem_write && (sel == REG_TL);
    assign tcon_wr = mem_write && (sel == REG_TCON);
    assign run     = (state == ST_RUN);

    // A TL write on a tick edge replaces both the increment and any overflow.
    assign ovf = run && tick_i && !tl_wr && (tl == 32'hFFFF_FFFF);

    always_comb begin
        enter_run = 1'b0;
        case (state)
            ST_IDLE: enter_run = tcon_wr && wdata[TCON_EN];
            ST_HALT: enter_run = tl_wr && tcon.en;
            default: enter_run = 1'b0;
        endcase
    end

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (rst_n),
        .clear (enter_run),
        .enable(run),
        .tick  (tick_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th    <= '0;
            tl    <= '0;
            tcon  <= '0;
            state <= ST_IDLE;
        end else begin
            if (th_wr) begin
                th <= wdata;
            end

            if (tl_wr) begin
                tl <= wdata;
            end else if (ovf) begin
                tl <= th;
            end else if (run && tick_i) begin
                tl <= tl + 32'd1;
            end

            if (tcon_wr) begin
                tcon.en <= wdata[TCON_EN];
                tcon.ie <= wdata[TCON_IE];
                tcon.os <= wdata[TCON_OS];
                if (wdata[TCON_IF]) begin
                    tcon.iflag <= 1'b0;
                end
            end

            // Overflow is placed after the bus write so its set and EN clear take priority.
            if (ovf) begin
                tcon.iflag <= 1'b1;
                if (tcon.os) begin
                    tcon.en <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (enter_run) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tcon_wr && !wdata[TCON_EN]) begin
                        state <= ST_IDLE;
                    end else if (ovf && tcon.os) begin
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (tcon_wr && !wdata[TCON_EN]) begin
                        state <= ST_IDLE;
                    end else if (enter_run) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign irq  = tcon.ie & tcon.iflag;
    assign tick = tick_i;

    always_comb begin
        rdata = '0;
        if (mem_read) begin
            case (sel)
                REG_TH:   rdata = th;
                REG_TL:   rdata = tl;
                REG_TCON: rdata = {28'd0, tcon};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/sys_timer.md
SYS_TIMER -- requirements
Module: sys_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clk cycles per timer tick (valid range 1..65535).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h4000_0000, meaning bus address of the TH register.
REQ-003 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset: asserts immediately when low, releases synchronously with clk.
REQ-005 SHALL have port mem_read  input  1  bus read strobe.
REQ-006 SHALL have port mem_write  input  1  bus write strobe, one cycle per write.
REQ-007 SHALL have port addr  input  32  word-aligned bus address.
REQ-008 SHALL have port wdata  input  32  bus write data.
REQ-009 SHALL have port rdata  output  32  bus read data.
REQ-010 SHALL have port irq  output  1  timer interrupt request, level.
REQ-011 SHALL have port tick  output  1  one-cycle prescaler tick pulse.

Function
REQ-012 SHALL map TH (reload value) at BASE_ADDR+0, TL (count) at +4 and TCON at +8; every other address decodes as unmapped.
REQ-013 SHALL define TCON bits as: [0] EN (count enable), [1] IE (interrupt enable), [2] IF (sticky overflow flag), [3] OS (one-shot mode); bits [31:4] read 0.
REQ-014 SHALL drive rdata combinationally in the same cycle as mem_read: the register value for mapped addresses, 0 for unmapped addresses or when mem_read=0.
REQ-015 SHALL run a prescaler counter 0..PRESCALE-1 only while state is RUN, and assert tick for exactly one cycle when it wraps; PRESCALE=1 gives tick every RUN cycle.
REQ-016 SHALL implement FSM states IDLE, RUN, HALT: IDLE->RUN when EN=1; RUN->IDLE when EN is written 0; RUN->HALT on overflow with OS=1; HALT->IDLE when EN is written 0; HALT->RUN when TL is written while EN=1.
REQ-017 SHALL, when state is RUN and tick=1, increment TL by 1 with 32-bit wrap.
REQ-018 SHALL treat TL=32'hFFFF_FFFF at a tick as overflow: TL<=TH, IF<=1, and, if OS=1, EN<=0 and state<=HALT in the same edge.
REQ-019 SHALL write TH and TL directly from wdata; a bus write to TL in the same cycle as a tick SHALL win, and the increment SHALL be discarded.
REQ-020 SHALL write TCON bits 0, 1 and 3 directly from wdata[0], wdata[1] and wdata[3]; IF SHALL be write-1-to-clear through wdata[2], and a write of 0 to wdata[2] SHALL leave IF unchanged.
REQ-021 SHALL give a set caused by overflow priority over a simultaneous IF clear.
REQ-022 SHALL drive irq = IE & IF from registers (no combinational path from the bus), with irq rising the cycle after the overflow edge.
REQ-023 SHALL reset the prescaler to 0 on any transition into RUN.

Reset
REQ-024 SHALL, while reset=0, force TH=0, TL=0, TCON=0, prescaler=0, state=IDLE, irq=0 and tick=0; rdata SHALL follow REQ-014 using these values.
REQ-025 SHALL abandon a count in progress on reset assertion mid-operation, with no overflow or irq generated after release until EN is rewritten.

Structure
REQ-026 SHALL place the register offsets (0, 4, 8), the TCON bit indices and the FSM state encodings in the shared peripheral package.
REQ-027 SHALL implement the prescaler as a sub-module named tick_prescaler (parameter PRESCALE; ports clk, reset, clear, enable, tick).

Verification
REQ-028 SHALL cover: reset low mid-count with TL=5 -> TL=0, TCON=0 and irq=0 immediately, and TL stays at 0 after release.
REQ-029 SHALL cover: PRESCALE=1, TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFC, TCON=3 -> overflow after 4 ticks, then TL=32'hFFFF_FFFC, IF=1, and irq=1 one cycle later.
REQ-030 SHALL cover: PRESCALE=4, EN=1 from TL=0 -> TL=1 after 4 cycles, TL=3 after 12 cycles, and tick period of exactly 4 cycles.
REQ-031 SHALL cover: OS=1, TL=32'hFFFF_FFFF, TCON=4'b1011 -> one overflow, then EN reads 0, state is HALT and TL stays at TH for 100 cycles.
REQ-032 SHALL cover: a write of TCON with wdata[2]=1 on the same edge as an overflow -> IF remains 1; a later write with wdata=32'h4 -> IF=0 and irq=0.
REQ-033 SHALL cover: a read at BASE_ADDR+12 -> rdata=0; a bus write to TL=32'h10 on a tick edge -> TL=32'h10.
